// File: rtl/wb_arbiter_pkg.sv
// datapath_pkg: shared writeback widths, source ids and registered writeback record types
package datapath_pkg;
    localparam int NUM_S_WB_SRC = 3;
    localparam int NUM_M_WB_SRC = 2;
    localparam int SREG_W       = 5;
    localparam int MREG_W       = 4;
    localparam int WORD_W       = 32;
    localparam int S_FU_W       = $clog2(NUM_S_WB_SRC);
    localparam int M_FU_W       = $clog2(NUM_M_WB_SRC);

    typedef enum logic [S_FU_W-1:0] {WB_ALU, WB_SMEM, WB_BR} wb_src_t;

    typedef struct packed {
        logic              we;
        logic [SREG_W-1:0] rd;
        logic [WORD_W-1:0] data;
        logic [S_FU_W-1:0] fu;
    } s_wb_t;

    typedef struct packed {
        logic [MREG_W-1:0] rd;
        logic [M_FU_W-1:0] fu;
    } m_wb_t;
endpackage

// File: rtl/wb_arbiter_rr_channel.sv
// wb_rr_channel: per-source one-entry holds, round-robin grant and registered winner output
// ports: clk_i/rst_ni/flush_i control; valid_i/payload_i/ready_o per-source handshake;
//        done_o one-cycle completion pulse with fu_o source index and payload_o winner payload
module wb_rr_channel #(
    parameter int N  = 3,
    parameter int PW = 37,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [N-1:0]    valid_i,
    input  logic [N*PW-1:0] payload_i,
    output logic [N-1:0]    ready_o,
    output logic            done_o,
    output logic [IW-1:0]   fu_o,
    output logic [PW-1:0]   payload_o
);
    logic [N-1:0]  hv_q;
    logic [PW-1:0] hold_q [N];
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gidx;
    logic [N-1:0]  gnt;
    logic          found;

    // grant looks only at the holds, keeping valid_i off the ready_o path
    always_comb begin : arb
        int j;
        found = 1'b0;
        gidx  = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!found && hv_q[j]) begin
                found = 1'b1;
                gidx  = IW'(j);
            end
        end
    end

    assign gnt     = found ? (N'(1) << gidx) : '0;
    assign ready_o = flush_i ? '0 : (~hv_q | gnt);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hv_q      <= '0;
            ptr_q     <= '0;
            done_o    <= 1'b0;
            fu_o      <= '0;
            payload_o <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (valid_i[i] && ready_o[i]) begin
                    hv_q[i]   <= 1'b1;
                    hold_q[i] <= payload_i[i*PW +: PW];
                end else if (gnt[i] || flush_i) begin
                    hv_q[i] <= 1'b0;
                end
            end
            done_o <= found && !flush_i;
            if (found && !flush_i) begin
                fu_o      <= gidx;
                payload_o <= hold_q[gidx];
                ptr_q     <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging scalar and matrix FU completions into one registered writeback each
// ports: CLK/nRST/flush control; s_valid/s_rd/s_data/s_ready scalar sources; m_valid/m_rd/m_ready matrix
//        sources; wb_done/wb_fu/wb_we/wb_rd/wb_data scalar writeback; wbm_done/wbm_fu/wbm_rd matrix release
module wb_arbiter
    import datapath_pkg::*;
#(
    parameter int NS     = NUM_S_WB_SRC,
    parameter int NM     = NUM_M_WB_SRC,
    parameter int SREG_W = datapath_pkg::SREG_W,
    parameter int MREG_W = datapath_pkg::MREG_W,
    parameter int WORD_W = datapath_pkg::WORD_W
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  flush,
    input  logic [NS-1:0]         s_valid,
    input  logic [NS*SREG_W-1:0]  s_rd,
    input  logic [NS*WORD_W-1:0]  s_data,
    output logic [NS-1:0]         s_ready,
    input  logic [NM-1:0]         m_valid,
    input  logic [NM*MREG_W-1:0]  m_rd,
    output logic [NM-1:0]         m_ready,
    output logic                  wb_done,
    output logic [$clog2(NS)-1:0] wb_fu,
    output logic                  wb_we,
    output logic [SREG_W-1:0]     wb_rd,
    output logic [WORD_W-1:0]     wb_data,
    output logic                  wbm_done,
    output logic [$clog2(NM)-1:0] wbm_fu,
    output logic [MREG_W-1:0]     wbm_rd
);
    localparam int SPW = SREG_W + WORD_W;

    logic [NS*SPW-1:0] s_pl;
    logic [SPW-1:0]    s_out;
    s_wb_t             s_wb;
    m_wb_t             m_wb;

    for (genvar g = 0; g < NS; g++) begin : g_pack
        assign s_pl[g*SPW +: SPW] = {s_rd[g*SREG_W +: SREG_W], s_data[g*WORD_W +: WORD_W]};
    end

    wb_rr_channel #(.N(NS), .PW(SPW)) u_s (
        .clk_i(CLK), .rst_ni(nRST), .flush_i(flush),
        .valid_i(s_valid), .payload_i(s_pl), .ready_o(s_ready),
        .done_o(wb_done), .fu_o(s_wb.fu), .payload_o(s_out)
    );

    wb_rr_channel #(.N(NM), .PW(MREG_W)) u_m (
        .clk_i(CLK), .rst_ni(nRST), .flush_i(flush),
        .valid_i(m_valid), .payload_i(m_rd), .ready_o(m_ready),
        .done_o(wbm_done), .fu_o(m_wb.fu), .payload_o(m_wb.rd)
    );

    // x0 writes still complete in the scoreboard but never reach the register file
    assign s_wb.rd   = s_out[SPW-1 -: SREG_W];
    assign s_wb.data = s_out[WORD_W-1:0];
    assign s_wb.we   = wb_done && (s_wb.rd != '0);

    assign wb_we   = s_wb.we;
    assign wb_rd   = s_wb.rd;
    assign wb_data = s_wb.data;
    assign wb_fu   = s_wb.fu;
    assign wbm_fu  = m_wb.fu;
    assign wbm_rd  = m_wb.rd;
endmodule
